// File: rtl/muldiv_pkg.sv
// Shared types and ALU opcodes for the iterative multiply/divide sequencer.
// The ALU opcodes are shared with the instruction decoder.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer. It borrows the core's
// shared ALU through a req/gnt handshake and performs one add (shift-add
// multiply) or one subtract (restoring divide) per granted cycle.
// Optional build macro: MULDIV_EARLY_OUT_EN adds accept-time early-out for
// zero multiply operands and for dividend < divisor.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  alu_req,
  input  logic                  alu_gnt,
  output logic [DATA_WIDTH-1:0] alu_srca,
  output logic [DATA_WIDTH-1:0] alu_srcb,
  output logic [3:0]            alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_ltu
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e                state_q, state_d;
  op_e                   op_q;
  // hi_q: acc_hi (multiply) or partial remainder (divide)
  // lo_q: multiplier/product-low (multiply) or dividend/quotient (divide)
  // opnd_q: multiplicand (multiply) or divisor (divide)
  logic [DATA_WIDTH-1:0] hi_q, lo_q, opnd_q, result_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  is_div;
  logic                  last_step;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  ovf, qbit, carry;
  logic [DATA_WIDTH-1:0] hi_n, lo_n, final_val;
  logic                  fast;
  logic [DATA_WIDTH-1:0] fast_val;

  assign is_div    = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign last_step = (cnt_q == CNT_ONE);
  assign shifted   = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
  assign ovf       = hi_q[DATA_WIDTH-1];

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign alu_req = (state_q == CALC);
  assign result  = result_q;

  // Accept-time shortcuts that finish without touching the ALU
  always_comb begin
    fast     = 1'b0;
    fast_val = '0;
    if (op[1] && (b == '0)) begin
      fast     = 1'b1;
      fast_val = op[0] ? a : '1;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!op[1] && ((a == '0) || (b == '0))) begin
      fast     = 1'b1;
      fast_val = '0;
    end
    else if (op[1] && (a < b)) begin
      fast     = 1'b1;
      fast_val = op[0] ? a : '0;
    end
`endif
  end

  // Drive the shared ALU only while calculating; zeros otherwise
  always_comb begin
    alu_srca = '0;
    alu_srcb = '0;
    alu_ctrl = ALU_ADD;
    if (state_q == CALC) begin
      if (is_div) begin
        alu_srca = shifted;
        alu_srcb = opnd_q;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_srca = hi_q;
        alu_srcb = lo_q[0] ? opnd_q : '0;
        alu_ctrl = ALU_ADD;
      end
    end
  end

  // One iteration of shift-add multiply or restoring divide from the ALU result
  always_comb begin
    carry = (alu_result < hi_q);
    qbit  = ovf | ~alu_ltu;
    if (is_div) begin
      hi_n = qbit ? alu_result : shifted;
      lo_n = {lo_q[DATA_WIDTH-2:0], qbit};
    end else begin
      hi_n = {carry, alu_result[DATA_WIDTH-1:1]};
      lo_n = {alu_result[0], lo_q[DATA_WIDTH-1:1]};
    end
    case (op_q)
      OP_MUL:  final_val = lo_n;
      OP_MULHU: final_val = hi_n;
      OP_DIVU: final_val = lo_n;
      default: final_val = hi_n;
    endcase
  end

  // FSM next-state: IDLE -> CALC (or DONE on fast path) -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = fast ? DONE : CALC;
      CALC:    if (alu_gnt && last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand/shift registers, step counter and result; all hold when not granted
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= OP_MUL;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            cnt_q  <= CNT_INIT;
            hi_q   <= '0;
            lo_q   <= op[1] ? a : b;
            opnd_q <= op[1] ? b : a;
            if (fast) result_q <= fast_val;
          end
        end
        CALC: begin
          if (alu_gnt) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_ONE;
            if (last_step) result_q <= final_val;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: a driver issues directed operations and
// queues the expected result and latency; a monitor checks every done pulse,
// reset state, idle ALU outputs and ALU output stability while stalled.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int N = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EO_LAT = 1;
`else
  localparam int EO_LAT = N + 1;
`endif

  logic         clk = 1'b0;
  logic         rst, start, alu_gnt;
  logic [1:0]   op;
  logic [N-1:0] a, b;
  logic         busy, done, alu_req, alu_ltu;
  logic [N-1:0] result, alu_srca, alu_srcb, alu_result;
  logic [3:0]   alu_ctrl;

  muldiv_seq #(.DATA_WIDTH(N)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .alu_req(alu_req), .alu_gnt(alu_gnt),
    .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_ltu(alu_ltu)
  );

  always #5 clk = ~clk;

  // Shared core ALU
  always_comb begin
    alu_result = (alu_ctrl == ALU_SUB) ? (alu_srca - alu_srcb) : (alu_srca + alu_srcb);
    alu_ltu    = (alu_srca < alu_srcb);
  end

  typedef struct {
    logic [N-1:0] res;
    int           lat;
    int           issue;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   timeouts = 0;
  bit   fin = 1'b0;
  logic rst_e = 1'b0;
  logic stall_e = 1'b0;

  // Cycle counter and per-edge samples of reset and stall
  initial begin
    forever begin
      @(posedge clk);
      cyc     <= cyc + 1;
      rst_e   <= rst;
      stall_e <= alu_req && !alu_gnt;
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t         e;
    logic [N-1:0] p_srca, p_srcb;
    logic [3:0]   p_ctrl;
    p_srca = '0; p_srcb = '0; p_ctrl = '0;
    forever begin
      @(negedge clk);
      if (rst_e) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || alu_req !== 1'b0 || result !== '0) begin
          errors++;
          $display("FAIL reset_state: busy=%b done=%b alu_req=%b result=%h, required 0 0 0 00000000",
                   busy, done, alu_req, result);
        end
      end
      if (!alu_req) begin
        checks++;
        if (alu_srca !== '0 || alu_srcb !== '0 || alu_ctrl !== ALU_ADD) begin
          errors++;
          $display("FAIL alu_idle: srca=%h srcb=%h ctrl=%b, required 0 0 0000",
                   alu_srca, alu_srcb, alu_ctrl);
        end
      end
      if (stall_e) begin
        checks++;
        if (alu_req !== 1'b1 || alu_srca !== p_srca || alu_srcb !== p_srcb || alu_ctrl !== p_ctrl) begin
          errors++;
          $display("FAIL alu_stall: req=%b srca=%h srcb=%h ctrl=%b, required 1 %h %h %b",
                   alu_req, alu_srca, alu_srcb, alu_ctrl, p_srca, p_srcb, p_ctrl);
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result=%h, required no done pulse", result);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (result !== e.res) begin
            errors++;
            $display("FAIL %s result: got %h, required %h", e.name, result, e.res);
          end
          checks++;
          if (cyc - e.issue != e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", e.name, cyc - e.issue, e.lat);
          end
        end
      end
      p_srca = alu_srca;
      p_srcb = alu_srcb;
      p_ctrl = alu_ctrl;
      if (cyc > 20000) begin
        $display("FAIL watchdog: cycle %0d, required finish before 20000", cyc);
        $fatal(1, "watchdog expired");
      end
      if (fin) begin
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL pending_ops: got %0d outstanding, required 0", exp_q.size());
        end
        checks++;
        if (timeouts != 0) begin
          errors++;
          $display("FAIL busy_timeout: got %0d timeouts, required 0", timeouts);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  // Follow an operation until busy drops, stalling the grant on masked CALC cycles
  task automatic wait_done(input logic [31:0] mask);
    int j;
    j = 0;
    while (busy && j < 80) begin
      alu_gnt = (j < 32) ? !mask[j] : 1'b1;
      @(negedge clk);
      j++;
    end
    alu_gnt = 1'b1;
    if (busy) timeouts++;
  endtask

  task automatic run(input logic [1:0] o, input logic [N-1:0] av, input logic [N-1:0] bv,
                     input logic [N-1:0] er, input int lat, input string nm,
                     input bit gated, input bit hold_start);
    logic [31:0] mask;
    int          n;
    int          r;
    mask = '0;
    n    = 0;
    if (gated) begin
      while (n < 5) begin
        r = int'($urandom_range(0, 31));
        if (!mask[r]) begin
          mask[r] = 1'b1;
          n++;
        end
      end
    end
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    exp_q.push_back('{res: er, lat: lat, issue: cyc, name: nm});
    @(negedge clk);
    // Holding start through CALC and DONE must not start a second operation
    start = hold_start;
    a = 32'hDEAD_BEEF; b = 32'h0000_0003;
    wait_done(mask);
    start = 1'b0;
  endtask

  // Driver
  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; alu_gnt = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, N + 1, "mul_basic",   1'b0, 1'b0);
    run(2'b01, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, N + 1, "mulhu_basic", 1'b0, 1'b0);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, N + 1, "mulhu_carry", 1'b0, 1'b0);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, N + 1, "mul_carry",   1'b0, 1'b0);
    run(2'b10, 32'd100,       32'd7,         32'd14,        N + 1, "divu_100_7",  1'b0, 1'b1);
    run(2'b11, 32'd100,       32'd7,         32'd2,         N + 1, "remu_100_7",  1'b0, 1'b0);
    run(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, N + 1, "divu_ovf",    1'b0, 1'b0);
    run(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, N + 1, "remu_ovf",    1'b0, 1'b0);
    run(2'b10, 32'h0000_5678, 32'h0000_0000, 32'hFFFF_FFFF, 1,     "divu_by0",    1'b0, 1'b0);
    run(2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1,     "remu_by0",    1'b0, 1'b0);
    run(2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, N + 6, "mul_stalled", 1'b1, 1'b0);
    run(2'b00, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, EO_LAT, "mul_zero",   1'b0, 1'b0);
    run(2'b10, 32'd3,         32'd9,         32'd0,         EO_LAT, "divu_small", 1'b0, 1'b0);
    run(2'b11, 32'd3,         32'd9,         32'd3,         EO_LAT, "remu_small", 1'b0, 1'b0);

    // Reset mid-CALC with start held: operation abandoned, no done pulse
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'h0001_0003; b = 32'h0002_0005;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{res: 32'h000B_000F, lat: N + 1, issue: cyc, name: "mul_after_rst"});
    @(negedge clk);
    start = 1'b0;
    wait_done('0);

    @(negedge clk);
    fin = 1'b1;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative unsigned multiply/divide sequencer for the RV32 core. It executes MUL, MULHU, DIVU and REMU by issuing one add or subtract per cycle to the core's single shared ALU, instead of instantiating its own wide arithmetic. It sits beside the execute stage and requests the ALU through a req/gnt handshake. It stalls whenever the main datapath keeps the grant.

## Interface
- DATA_WIDTH, 32, operand/result width (N)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  accept new operation when state is IDLE
- op  in  2  00 MUL (low N), 01 MULHU (high N), 10 DIVU, 11 REMU
- a  in  N  multiplicand / dividend
- b  in  N  multiplier / divisor
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse when result is valid
- result  out  N  final value, held until the next accepted start
- alu_req  out  1  high exactly while state is CALC
- alu_gnt  in  1  ALU is granted to this block this cycle
- alu_srca  out  N  shared ALU operand A
- alu_srcb  out  N  shared ALU operand B
- alu_ctrl  out  4  ALU opcode: 4'b0000 add, 4'b1000 sub
- alu_result  in  N  shared ALU result, same cycle (combinational)
- alu_ltu  in  1  shared ALU unsigned-less-than flag for srca < srcb

## Operation
- States: IDLE, CALC, DONE.
- IDLE + start:
  - Latch operands and op; load counter = N.
  - Go to CALC, except for the fast-path cases below, which go to DONE.
- start while busy is ignored; there is no queueing.
- Divide by zero (op[1]=1, b=0): go directly to DONE.
  - DIVU result = all ones.
  - REMU result = a.
- MUL/MULHU registers:
  - acc_hi = 0, mq = b, mcand = a.
- MUL/MULHU, each granted CALC cycle:
  - Drive srca = acc_hi, srcb = mq[0] ? mcand : 0, ctrl = add.
  - carry = (alu_result < acc_hi), computed with an internal compare.
  - acc_hi <= {carry, alu_result[N-1:1]}.
  - mq <= {alu_result[0], mq[N-1:1]}.
- MUL/MULHU completion: after N steps, MUL = mq and MULHU = acc_hi.
- DIVU/REMU registers:
  - rem = 0, dq = a, dvsr = b.
- DIVU/REMU, each granted CALC cycle:
  - shifted = {rem[N-2:0], dq[N-1]}, ovf = rem[N-1].
  - Drive srca = shifted, srcb = dvsr, ctrl = sub.
  - qbit = ovf | ~alu_ltu.
  - rem <= qbit ? alu_result : shifted.
  - dq <= {dq[N-2:0], qbit}.
- DIVU/REMU completion: after N steps, DIVU = dq and REMU = rem.
- Counter decrements on each granted CALC cycle. On the step where the counter reaches 0, register the result and go to DONE.
- DONE: done = 1 for one cycle, then go to IDLE. result remains stable afterwards.
- alu_gnt low during CALC: all registers and the counter hold, and ALU outputs keep the same values.
- Outside CALC: alu_srca = alu_srcb = 0, alu_ctrl = 4'b0000.

## Timing
- Reset: state IDLE; busy = 0, done = 0, alu_req = 0, result = 0; all internal registers 0. Applies even mid-CALC; the operation is abandoned with no done pulse.
- start sampled at edge 0 with full grant: done is high in cycle N+1 (N CALC cycles plus DONE). busy is high for cycles 1..N+1.
- Each grant-low cycle during CALC adds exactly one cycle of latency.
- Fast path (divide by zero, or early-out when enabled): done in cycle 1.
- start in the DONE cycle is ignored. start in the cycle after DONE (state IDLE) is accepted, so back-to-back operations are spaced N+2 cycles apart.

## Configuration
- MULDIV_EARLY_OUT_EN defined: extra fast-path cases at accept time, each finishing with done in cycle 1:
  - MUL/MULHU with a = 0 or b = 0: result = 0.
  - DIVU/REMU with b != 0 and a < b (internal unsigned compare): DIVU result = 0, REMU result = a.
- Undefined: these cases take the full iterative path and produce identical results after N+1 cycles. Divide-by-zero fast path exists in both builds.

## Structure
- muldiv_pkg holds:
  - op_e enum (OP_MUL, OP_MULHU, OP_DIVU, OP_REMU).
  - state_e enum (IDLE, CALC, DONE).
  - ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, shared with the decoder.
- No sub-module. The ALU stays external and shared; the block contains the FSM, counter, shift registers and the carry compare only.

## Test plan
- MUL, a=0x0001_0003, b=0x0002_0005, gnt=1 -> done at cycle 33, result 0x000B_000F; MULHU on the same operands -> 0x0000_0002.
- MULHU, a=b=0xFFFF_FFFF -> 0xFFFF_FFFE; MUL on the same operands -> 0x0000_0001 (exercises carry).
- DIVU, a=100, b=7 -> 14; REMU -> 2. DIVU, a=0xFFFF_FFFF, b=0x8000_0001 -> 1 (exercises ovf path); REMU -> 0x7FFF_FFFE.
- DIVU, b=0 -> done at cycle 1, result 0xFFFF_FFFF; REMU, a=0x1234 -> 0x1234.
- MUL with alu_gnt low for 5 random CALC cycles -> done at cycle 38, same result as the ungated run, ALU outputs stable while stalled.
- rst asserted mid-CALC with start held high -> next cycle busy = 0, done = 0, result = 0; start is accepted the cycle after rst deasserts. With MULDIV_EARLY_OUT_EN, DIVU a=3, b=9 -> done at cycle 1, result 0.
